ec_data_access: RTL and testbench
=================================

Name: ec_data_access

Overview:
- Data-memory access stage for the EC slot of the pipeline, located directly upstream of the EC/WB segment register.
- Takes the memory operation of the instruction held in EC and drives a single-outstanding SRAM-like data port (req/addr_ok/data_ok).
- Generates the pipeline stall while an access is pending and registers the returned read data as ec_data_rdata.
- Handles exception flush (refresh) mid-transaction by draining the access and discarding its result.

Parameters:
None.

Ports:
clk  in  1  clock
resetn  in  1  reset; asynchronous, active-low
refresh  in  1  pipeline flush (exception/eret); kills the current EC instruction
seg_stall  in  1  stall applied to the EC/WB segment register this cycle
ec_valid  in  1  EC holds a valid instruction
ec_ex  in  1  EC instruction already carries an exception; suppresses its access
ec_load  in  1  instruction is a load
ec_store  in  1  instruction is a store
ec_lsV  in  4  byte lanes accessed
ec_addr  in  32  effective address
ec_wdata  in  32  lane-aligned store data
data_req  out  1  SRAM-like request
data_wr  out  1  1 = write
data_size  out  2  0 = byte, 1 = half, 2 = word
data_addr  out  32  request address
data_wdata  out  32  write data
data_addr_ok  in  1  request accepted
data_data_ok  in  1  read data or write acknowledge returned
data_rdata  in  32  read data
ec_data_rdata  out  32  registered read data, valid in DONE
ec_data_req  out  1  EC instruction performed an access (forwarded into EC/WB)
mem_stall  out  1  stall request to the pipeline controller

Behaviour:
- issue = ec_valid & (ec_load | ec_store) & ~ec_ex & ~refresh.
- State encoding: IDLE, ADDR, DATA, DONE, DRAIN_A, DRAIN_D.
- Reset (asynchronous, resetn = 0): state = IDLE, data_req = 0, data_wr = 0, data_size = 0, data_addr = 0, data_wdata = 0, ec_data_rdata = 0, ec_data_req = 0, mem_stall = 0. Reset mid-transaction abandons the access with no drain.
- IDLE: if issue, latch wr = ec_store, addr = ec_addr, wdata = ec_wdata, and size from ec_lsV; go to ADDR.
  - Size mapping: 1111 -> 2; 0011 or 1100 -> 1; single lane -> 0; any other pattern -> 2.
- ADDR: data_req = 1 and the latched fields are held stable until accepted.
  - addr_ok & ~refresh -> DATA.
  - addr_ok & refresh -> DRAIN_D.
  - ~addr_ok & refresh -> DRAIN_A. The request is never withdrawn once raised.
- DATA: data_req = 0.
  - data_ok & ~refresh -> DONE, with ec_data_rdata <= data_rdata. For stores, ec_data_rdata is left unchanged.
  - refresh (with or without data_ok) -> DRAIN_D; if data_ok arrived in the same cycle, go to IDLE instead and discard the data.
- DONE: result held. If refresh or ~seg_stall, go to IDLE. No reissue occurs from DONE.
- DRAIN_A: data_req = 1 until addr_ok, then -> DRAIN_D.
- DRAIN_D: on data_ok -> IDLE; the data is discarded and ec_data_rdata is not updated.
- data_ok is sampled only in DATA and DRAIN_D. The data port guarantees data_ok arrives at least 1 cycle after addr_ok.
- mem_stall (combinational) = (IDLE & issue) | ADDR | DATA | ((DRAIN_A | DRAIN_D) & ec_valid & (ec_load | ec_store)).
  - mem_stall is deasserted in DONE so the segment register can advance.
  - In DRAIN states a new memory instruction waits; a non-memory instruction passes.
- ec_data_req = 1 in DONE, else 0.
- Minimum load latency, with instruction arriving in cycle 0:
  - cycle 1: req and addr_ok;
  - cycle 2: data_ok;
  - cycle 3: DONE with ec_data_rdata valid and mem_stall = 0.

Test Plan:
- Word load: addr 0x8000_0010, lsV 1111, addr_ok in cycle 1, data_ok in cycle 2 with rdata 0xDEAD_BEEF -> data_size = 2, mem_stall = 1 in cycles 0-2, DONE in cycle 3 with ec_data_rdata = 0xDEAD_BEEF and ec_data_req = 1.
- Byte store: lsV 0100, wdata 0x00AB_0000, addr_ok withheld 3 cycles -> data_req held for 4 cycles with addr/wdata stable, data_wr = 1, data_size = 0; ec_data_rdata unchanged.
- Refresh in ADDR before addr_ok -> req stays high until addr_ok, state DRAIN_D; data_ok with rdata 0x1234_5678 is discarded, ec_data_rdata keeps its old value, then IDLE.
- Refresh in the same cycle as data_ok in DATA -> IDLE next cycle, no DONE, ec_data_req = 0.
- Load in DONE with seg_stall = 1 for 2 cycles -> DONE held, no second req; when seg_stall drops -> IDLE; a following load issues exactly one new req.
- resetn pulled low in DATA -> all outputs 0 immediately, state IDLE; a stale data_ok after reset is ignored.

Source files
------------

// File: rtl/ec_data_access.sv
// rtl/ec_data_access.sv - EC-stage data-memory access over a single-outstanding SRAM-like port
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   refresh                pipeline flush; kills the EC instruction
//   seg_stall              EC/WB segment register stall this cycle
//   ec_valid, ec_ex        EC instruction valid / already excepted
//   ec_load, ec_store      memory operation kind
//   ec_lsV, ec_addr,
//   ec_wdata               byte lanes, effective address, lane-aligned store data
//   data_req .. data_wdata request side of the data port
//   data_addr_ok,
//   data_data_ok,
//   data_rdata             response side of the data port
//   ec_data_rdata          registered read data, valid in DONE
//   ec_data_req            EC instruction performed an access (DONE)
//   mem_stall              stall request to the pipeline controller

module ec_data_access (
  input  logic        clk,
  input  logic        resetn,
  input  logic        refresh,
  input  logic        seg_stall,
  input  logic        ec_valid,
  input  logic        ec_ex,
  input  logic        ec_load,
  input  logic        ec_store,
  input  logic [3:0]  ec_lsV,
  input  logic [31:0] ec_addr,
  input  logic [31:0] ec_wdata,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] ec_data_rdata,
  output logic        ec_data_req,
  output logic        mem_stall
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    DATA    = 3'd2,
    DONE    = 3'd3,
    DRAIN_A = 3'd4,
    DRAIN_D = 3'd5
  } state_t;

  state_t state;

  logic is_mem;
  logic issue;

  assign is_mem = ec_valid & (ec_load | ec_store);
  assign issue  = is_mem & ~ec_ex & ~refresh;

  // Contiguous half-word and full-word masks get their natural size;
  // irregular lane patterns fall back to a word access.
  function automatic logic [1:0] size_of(input logic [3:0] lsv);
    case (lsv)
      4'b1111:                            size_of = 2'd2;
      4'b0011, 4'b1100:                   size_of = 2'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size_of = 2'd0;
      default:                            size_of = 2'd2;
    endcase
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      data_wr       <= 1'b0;
      data_size     <= 2'd0;
      data_addr     <= 32'd0;
      data_wdata    <= 32'd0;
      ec_data_rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            data_wr    <= ec_store;
            data_size  <= size_of(ec_lsV);
            data_addr  <= ec_addr;
            data_wdata <= ec_wdata;
            state      <= ADDR;
          end
        end
        // Once raised the request stays up; a flush only redirects where
        // the accepted transaction is drained.
        ADDR: begin
          if (data_addr_ok)
            state <= refresh ? DRAIN_D : DATA;
          else if (refresh)
            state <= DRAIN_A;
        end
        DATA: begin
          if (refresh)
            state <= data_data_ok ? IDLE : DRAIN_D;
          else if (data_data_ok) begin
            state <= DONE;
            if (!data_wr)
              ec_data_rdata <= data_rdata;
          end
        end
        // Hold the result until the segment register takes it.
        DONE: begin
          if (refresh || !seg_stall)
            state <= IDLE;
        end
        DRAIN_A: begin
          if (data_addr_ok)
            state <= DRAIN_D;
        end
        DRAIN_D: begin
          if (data_data_ok)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign data_req    = (state == ADDR) || (state == DRAIN_A);
  assign ec_data_req = (state == DONE);

  // Gated by resetn so the stall is dropped for the whole reset window.
  // While draining, only a memory instruction has to wait for the port.
  always_comb begin
    mem_stall = 1'b0;
    case (state)
      IDLE:             mem_stall = issue;
      ADDR, DATA:       mem_stall = 1'b1;
      DRAIN_A, DRAIN_D: mem_stall = is_mem;
      default:          mem_stall = 1'b0;
    endcase
    mem_stall = mem_stall & resetn;
  end

endmodule

// File: tb/tb_ec_data_access.sv
// tb/tb_ec_data_access.sv - directed self-checking bench for ec_data_access

module tb_ec_data_access;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        refresh = 1'b0;
  logic        seg_stall = 1'b0;
  logic        ec_valid = 1'b0;
  logic        ec_ex = 1'b0;
  logic        ec_load = 1'b0;
  logic        ec_store = 1'b0;
  logic [3:0]  ec_lsV = 4'd0;
  logic [31:0] ec_addr = 32'd0;
  logic [31:0] ec_wdata = 32'd0;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic [31:0] data_rdata = 32'd0;
  logic [31:0] ec_data_rdata;
  logic        ec_data_req;
  logic        mem_stall;

  int total = 0;
  int bad = 0;
  int hs = 0;

  ec_data_access dut (
    .clk(clk), .resetn(resetn), .refresh(refresh), .seg_stall(seg_stall),
    .ec_valid(ec_valid), .ec_ex(ec_ex), .ec_load(ec_load), .ec_store(ec_store),
    .ec_lsV(ec_lsV), .ec_addr(ec_addr), .ec_wdata(ec_wdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .ec_data_rdata(ec_data_rdata), .ec_data_req(ec_data_req), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  // Accepted request handshakes seen on the port.
  always @(posedge clk) if (resetn && data_req && data_addr_ok) hs = hs + 1;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_op(input logic st, input logic [3:0] lsv, input logic [31:0] a, input logic [31:0] wd);
    ec_valid = 1'b1; ec_load = ~st; ec_store = st; ec_lsV = lsv; ec_addr = a; ec_wdata = wd;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #12;
    total++;
    if ({data_req, data_wr, data_size, data_addr, data_wdata, ec_data_rdata, ec_data_req, mem_stall} !== 72'd0) begin
      bad++; $display("FAIL reset_outputs: got req=%b wr=%b size=%0d addr=%h wdata=%h rdata=%h dreq=%b stall=%b want all 0",
        data_req, data_wr, data_size, data_addr, data_wdata, ec_data_rdata, ec_data_req, mem_stall);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_word_load();
    nxt();
    mem_op(1'b0, 4'b1111, 32'h8000_0010, 32'd0);
    #1;
    total++;
    if ({mem_stall, data_req} !== 2'b10) begin
      bad++; $display("FAIL wl_c0: stall,req=%b want 10", {mem_stall, data_req});
    end
    nxt();
    data_addr_ok = 1'b1;
    #1;
    total++;
    if ({data_req, data_wr, data_size, mem_stall, data_addr} !== {1'b1, 1'b0, 2'd2, 1'b1, 32'h8000_0010}) begin
      bad++; $display("FAIL wl_c1: req=%b wr=%b size=%0d stall=%b addr=%h want 1 0 2 1 80000010",
        data_req, data_wr, data_size, mem_stall, data_addr);
    end
    nxt();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    #1;
    total++;
    if ({data_req, mem_stall} !== 2'b01) begin
      bad++; $display("FAIL wl_c2: req,stall=%b want 01", {data_req, mem_stall});
    end
    nxt();
    data_data_ok = 1'b0;
    #1;
    total++;
    if ({ec_data_req, mem_stall, data_req, ec_data_rdata} !== {3'b100, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL wl_c3: dreq=%b stall=%b req=%b rdata=%h want 1 0 0 deadbeef",
        ec_data_req, mem_stall, data_req, ec_data_rdata);
    end
    ec_valid = 1'b0;
    nxt();
    total++;
    if ({ec_data_req, data_req, mem_stall} !== 3'b000) begin
      bad++; $display("FAIL wl_idle: dreq,req,stall=%b want 000", {ec_data_req, data_req, mem_stall});
    end
  endtask

  task automatic test_byte_store();
    mem_op(1'b1, 4'b0100, 32'h8000_0026, 32'h00AB_0000);
    for (int c = 1; c <= 4; c++) begin
      nxt();
      if (c == 4) data_addr_ok = 1'b1;
      #1;
      total++;
      if ({data_req, data_wr, data_size, data_addr, data_wdata, mem_stall} !==
          {1'b1, 1'b1, 2'd0, 32'h8000_0026, 32'h00AB_0000, 1'b1}) begin
        bad++; $display("FAIL bs_hold_c%0d: req=%b wr=%b size=%0d addr=%h wdata=%h stall=%b want 1 1 0 80000026 00ab0000 1",
          c, data_req, data_wr, data_size, data_addr, data_wdata, mem_stall);
      end
    end
    nxt();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5555_5555;
    nxt();
    data_data_ok = 1'b0;
    #1;
    total++;
    if ({ec_data_req, ec_data_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL bs_done: dreq=%b rdata=%h want 1 deadbeef", ec_data_req, ec_data_rdata);
    end
    ec_valid = 1'b0;
    nxt();
  endtask

  task automatic test_refresh_addr();
    mem_op(1'b0, 4'b0011, 32'h0000_0100, 32'd0);
    nxt();
    refresh = 1'b1; ec_valid = 1'b0;
    #1;
    total++;
    if ({data_req, data_size} !== 3'b1_01) begin
      bad++; $display("FAIL ra_addr: req=%b size=%0d want 1 1", data_req, data_size);
    end
    nxt();
    refresh = 1'b0;
    #1;
    total++;
    if ({data_req, mem_stall} !== 2'b10) begin
      bad++; $display("FAIL ra_drain_a: req,stall=%b want 10", {data_req, mem_stall});
    end
    data_addr_ok = 1'b1;
    nxt();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    mem_op(1'b0, 4'b1111, 32'h0000_0200, 32'd0);
    #1;
    total++;
    if ({data_req, mem_stall} !== 2'b01) begin
      bad++; $display("FAIL ra_drain_d: req,stall=%b want 01", {data_req, mem_stall});
    end
    nxt();
    data_data_ok = 1'b0; ec_valid = 1'b0;
    #1;
    total++;
    if ({ec_data_req, data_req, ec_data_rdata} !== {2'b00, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL ra_discard: dreq=%b req=%b rdata=%h want 0 0 deadbeef", ec_data_req, data_req, ec_data_rdata);
    end
    nxt();
  endtask

  task automatic test_refresh_data_ok();
    mem_op(1'b0, 4'b0001, 32'h0000_0300, 32'd0);
    nxt();
    data_addr_ok = 1'b1;
    #1;
    total++;
    if ({data_req, data_size} !== 3'b1_00) begin
      bad++; $display("FAIL rd_size: req=%b size=%0d want 1 0", data_req, data_size);
    end
    nxt();
    data_addr_ok = 1'b0; refresh = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D; ec_valid = 1'b0;
    nxt();
    refresh = 1'b0; data_data_ok = 1'b0;
    #1;
    total++;
    if ({ec_data_req, data_req, mem_stall, ec_data_rdata} !== {3'b000, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL rd_no_done: dreq=%b req=%b stall=%b rdata=%h want 0 0 0 deadbeef",
        ec_data_req, data_req, mem_stall, ec_data_rdata);
    end
  endtask

  task automatic test_done_hold();
    int hs0;
    // Issued straight away: only possible if the previous access ended in IDLE.
    mem_op(1'b0, 4'b1100, 32'h0000_0400, 32'd0);
    nxt();
    data_addr_ok = 1'b1;
    #1;
    total++;
    if ({data_req, data_size, data_addr} !== {1'b1, 2'd1, 32'h0000_0400}) begin
      bad++; $display("FAIL dh_issue: req=%b size=%0d addr=%h want 1 1 00000400", data_req, data_size, data_addr);
    end
    nxt();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1122_3344; seg_stall = 1'b1;
    nxt();
    data_data_ok = 1'b0;
    hs0 = hs;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if ({ec_data_req, data_req, mem_stall, ec_data_rdata} !== {3'b100, 32'h1122_3344}) begin
        bad++; $display("FAIL dh_hold_c%0d: dreq=%b req=%b stall=%b rdata=%h want 1 0 0 11223344",
          c, ec_data_req, data_req, mem_stall, ec_data_rdata);
      end
      if (c == 1) seg_stall = 1'b0;
      nxt();
    end
    mem_op(1'b0, 4'b1111, 32'h0000_0500, 32'd0);
    #1;
    total++;
    if ({ec_data_req, data_req, mem_stall} !== 3'b001) begin
      bad++; $display("FAIL dh_idle: dreq,req,stall=%b want 001", {ec_data_req, data_req, mem_stall});
    end
    nxt();
    data_addr_ok = 1'b1;
    nxt();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0000_0099;
    nxt();
    data_data_ok = 1'b0; ec_valid = 1'b0;
    #1;
    total++;
    if ({hs - hs0, ec_data_req, ec_data_rdata} !== {32'd1, 1'b1, 32'h0000_0099}) begin
      bad++; $display("FAIL dh_one_req: handshakes=%0d dreq=%b rdata=%h want 1 1 00000099", hs - hs0, ec_data_req, ec_data_rdata);
    end
    nxt();
  endtask

  task automatic test_reset_mid();
    mem_op(1'b1, 4'b1111, 32'h0000_0600, 32'hA5A5_A5A5);
    nxt();
    data_addr_ok = 1'b1;
    nxt();
    data_addr_ok = 1'b0; resetn = 1'b0;
    #1;
    total++;
    if ({data_req, data_wr, data_size, data_addr, data_wdata, ec_data_rdata, ec_data_req, mem_stall} !== 72'd0) begin
      bad++; $display("FAIL rm_outputs: req=%b wr=%b size=%0d addr=%h wdata=%h rdata=%h dreq=%b stall=%b want all 0",
        data_req, data_wr, data_size, data_addr, data_wdata, ec_data_rdata, ec_data_req, mem_stall);
    end
    nxt();
    resetn = 1'b1; ec_valid = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0000_0077;
    nxt();
    data_data_ok = 1'b0;
    #1;
    total++;
    if ({ec_data_req, data_req, mem_stall, ec_data_rdata} !== {3'b000, 32'd0}) begin
      bad++; $display("FAIL rm_stale: dreq=%b req=%b stall=%b rdata=%h want 0 0 0 00000000",
        ec_data_req, data_req, mem_stall, ec_data_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_refresh_addr();
    test_refresh_data_ok();
    test_done_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
